// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Holds the default operand/segment widths, the pipeline-depth derivation
// and a single full-adder cell used to build ripple segments.
package rca_pkg;

  localparam int unsigned RCA_WIDTH = 16;
  localparam int unsigned RCA_SEG   = 4;

  // Pipeline depth: one stage per ripple segment.
  function automatic int unsigned rca_stages(input int unsigned width, input int unsigned seg);
    return (seg == 0) ? 1 : width / seg;
  endfunction

  // Full-adder cell, returns {carry_out, sum}.
  function automatic logic [1:0] rca_fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/seg_rca.sv
// Combinational SEG-bit ripple segment built from full-adder cells.
// Ports:
//   a, b  - segment operands
//   cin   - carry into bit 0
//   s     - segment sum
//   cout  - carry out of the segment MSB
module seg_rca
  import rca_pkg::*;
#(
  parameter int unsigned SEG = RCA_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0] c;

  // Carry chain: bit i consumes c[i] and produces c[i+1].
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SEG; i++) begin
      {c[i+1], s[i]} = rca_fa(a[i], b[i], c[i]);
    end
  end

  assign cout = c[SEG];

endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshaking.
// Each stage adds one SEG-bit segment; unconsumed operand segments move
// forward in skew registers and finished sum segments in deskew registers.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake (in_ready = pipeline advance)
//   a, b, cin, sub      - operands, carry in, subtract select (a-b when 1)
//   out_valid/out_ready - result handshake
//   s, cout, ovf        - result, carry out of MSB, signed overflow
module pipe_rca
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_WIDTH,
  parameter int unsigned SEG   = RCA_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = rca_stages(WIDTH, SEG);
  localparam int unsigned SKEW   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned TOP    = WIDTH - SEG;

  // Elaboration-time configuration check.
  if (SEG == 0) begin : g_cfg_seg_zero
    $error("pipe_rca: SEG must be non-zero");
  end else if ((WIDTH % SEG) != 0) begin : g_cfg_not_multiple
    $error("pipe_rca: WIDTH must be an integer multiple of SEG");
  end

  logic              adv_c;
  logic [WIDTH-1:0]  b_eff_c;
  logic              cin_eff_c;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cry_q, cry_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  opa_q [SKEW];
  logic [WIDTH-1:0]  opa_d [SKEW];
  logic [WIDTH-1:0]  opb_q [SKEW];
  logic [WIDTH-1:0]  opb_d [SKEW];

  logic [WIDTH-1:0]  stg_a [STAGES];
  logic [WIDTH-1:0]  stg_b [STAGES];
  logic [SEG-1:0]    seg_a [STAGES];
  logic [SEG-1:0]    seg_b [STAGES];
  logic [SEG-1:0]    seg_s [STAGES];
  logic [STAGES-1:0] seg_ci;
  logic [STAGES-1:0] seg_co;

  assign adv_c = ~vld_q[STAGES-1] | out_ready;

  // Subtraction is folded in at entry (~b, carry-in 1), so the operation
  // kind travels with the operands without a separate per-stage flag.
  assign b_eff_c   = sub ? ~b : b;
  assign cin_eff_c = sub | cin;

  // Stage operand/carry selection: stage 0 from ports, later stages from skew.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      stg_a[k] = '0;
      stg_b[k] = '0;
      seg_a[k] = '0;
      seg_b[k] = '0;
    end
    seg_ci    = '0;
    stg_a[0]  = a;
    stg_b[0]  = b_eff_c;
    seg_ci[0] = cin_eff_c;
    for (int unsigned k = 1; k < STAGES; k++) begin
      stg_a[k]  = opa_q[k-1];
      stg_b[k]  = opb_q[k-1];
      seg_ci[k] = cry_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_a[k] = stg_a[k][SEG-1:0];
      seg_b[k] = stg_b[k][SEG-1:0];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    seg_rca #(.SEG(SEG)) u_seg (
      .a    (seg_a[k]),
      .b    (seg_b[k]),
      .cin  (seg_ci[k]),
      .s    (seg_s[k]),
      .cout (seg_co[k])
    );
  end

  // Next-state: new segment enters the sum at the top and earlier segments
  // shift down, so after the last stage segment 0 sits at bit 0.
  always_comb begin
    vld_d = '0;
    cry_d = '0;
    ovf_d = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum_d[k] = '0;
    end
    for (int unsigned k = 0; k < SKEW; k++) begin
      opa_d[k] = '0;
      opb_d[k] = '0;
    end
    vld_d[0] = in_valid;
    sum_d[0] = WIDTH'(seg_s[0]) << TOP;
    for (int unsigned k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      sum_d[k] = (sum_q[k-1] >> SEG) | (WIDTH'(seg_s[k]) << TOP);
    end
    cry_d = seg_co;
    for (int unsigned k = 0; k + 1 < STAGES; k++) begin
      opa_d[k] = stg_a[k] >> SEG;
      opb_d[k] = stg_b[k] >> SEG;
    end
    // Carry into the MSB recovered as a^b^s at that bit.
    ovf_d = stg_a[STAGES-1][SEG-1] ^ stg_b[STAGES-1][SEG-1]
          ^ seg_s[STAGES-1][SEG-1] ^ seg_co[STAGES-1];
  end

  // Data registers load only for valid slots so bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cry_q <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
      for (int unsigned k = 0; k < SKEW; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else if (adv_c) begin
      vld_q <= vld_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (vld_d[k]) begin
          sum_q[k] <= sum_d[k];
          cry_q[k] <= cry_d[k];
        end
      end
      for (int unsigned k = 0; k + 1 < STAGES; k++) begin
        if (vld_d[k]) begin
          opa_q[k] <= opa_d[k];
          opb_q[k] <= opb_d[k];
        end
      end
      if (vld_d[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = adv_c;
  assign out_valid = vld_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign cout      = cry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: doc/pipe_rca.md
PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL have parameter SEG, default 4: ripple segment width in bits; WIDTH SHALL be an integer multiple of SEG.
REQ-003 The block SHALL derive STAGES = WIDTH/SEG as its pipeline depth.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid SHALL be an input, 1 bit: operands present.
REQ-007 Port in_ready SHALL be an output, 1 bit: block can accept operands this cycle.
REQ-008 Ports a and b SHALL be inputs, WIDTH bits each: the operands.
REQ-009 Port cin SHALL be an input, 1 bit: carry in, used when sub=0.
REQ-010 Port sub SHALL be an input, 1 bit: 1 selects a-b, 0 selects a+b+cin.
REQ-011 Port out_valid SHALL be an output, 1 bit: result present.
REQ-012 Port out_ready SHALL be an input, 1 bit: consumer accepts the result.
REQ-013 Port s SHALL be an output, WIDTH bits: sum or difference.
REQ-014 Port cout SHALL be an output, 1 bit: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-015 Port ovf SHALL be an output, 1 bit: two's-complement signed overflow.

Function
REQ-016 Transfers SHALL follow valid/ready: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
REQ-017 The pipeline SHALL advance as a whole when adv = !out_valid | out_ready, and hold every register otherwise; in_ready SHALL equal adv.
REQ-018 Stage k (0..STAGES-1) SHALL add operand bits [k*SEG +: SEG] plus the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-019 When sub=1, the block SHALL use ~b as the second operand and force the effective carry-in to 1, ignoring cin; sub SHALL travel with its operands.
REQ-020 Operand segments not yet consumed SHALL be carried forward in skew registers, and completed sum segments SHALL be carried forward in deskew registers, so that s is aligned when it reaches the output.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid in the absence of stalls.
REQ-022 Throughput SHALL be one operation per cycle when out_ready stays high.
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid=0 while adv) SHALL propagate as invalid slots without corrupting neighbouring results.
REQ-024 Output ports s, cout and ovf SHALL be taken from the last stage's registers and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH, with cout as bit WIDTH.
REQ-027 When adv=1, a simultaneous output consume and input accept in the same cycle SHALL both succeed.

Reset
REQ-028 Assertion of rst_n=0 SHALL immediately clear all stage valid bits, carries and data registers to 0, regardless of the clock.
REQ-029 During and after reset, until the first accepted input has propagated, out_valid, s, cout and ovf SHALL read 0, and in_ready SHALL read 1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight results; no partial result SHALL emerge afterwards.

Structure
REQ-031 Shared package rca_pkg SHALL hold the default WIDTH and SEG constants and the STAGES derivation function.
REQ-032 Sub-module seg_rca SHALL be a combinational SEG-bit ripple segment built from full-adder cells, with ports a, b, cin, s and cout; it SHALL be instantiated once per stage.
REQ-033 A static check SHALL reject configurations where WIDTH % SEG != 0.

Verification (WIDTH=16, SEG=4)
REQ-034 Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0 -> exactly 4 cycles later s=0x0000, cout=1, ovf=0.
REQ-035 Subtraction with borrow: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, cout=0, ovf=0.
REQ-036 Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, ovf=1, cout=0.
REQ-037 Streaming and stall: 8 back-to-back inputs -> 8 outputs on consecutive cycles in order; holding out_ready=0 for 3 cycles keeps s stable and in_ready=0, and no result is lost or duplicated.
REQ-038 Reset mid-stream: assert rst_n=0 with 3 results in flight -> out_valid=0 and s=0 immediately; after release, the first new input emerges 4 cycles later and no stale result appears.
